uart_arbiter: RTL and testbench
===============================

UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N_CPU  4  number of CPU requesters
  ID_W  2  width of a requester index
  DATA_W  8  UART data width
  MAX_HOLD  1024  grant cycles before a pending requester may preempt
REQ-002 Ports (name  direction  width  meaning):
  clk  in  1  system clock, single clock domain
  rst  in  1  synchronous, active-high reset
  cpu_req  in  N_CPU  per-CPU level request for the UART
  cpu_rd  in  N_CPU  per-CPU read strobe
  cpu_wr  in  N_CPU  per-CPU write strobe
  cpu_addr  in  N_CPU  per-CPU UART register address
  cpu_din  in  N_CPU*DATA_W  write data; CPU i at [i*DATA_W +: DATA_W]
  cpu_dout  out  N_CPU*DATA_W  read data, same packing
  cpu_gnt  out  N_CPU  one-hot grant, registered
  force_en  in  1  manual owner override enable
  force_id  in  ID_W  manual owner index
  uart_rd  out  1  to UART io_rd
  uart_wr  out  1  to UART io_wr
  uart_addr  out  1  to UART io_addr
  uart_din  out  DATA_W  to UART io_din
  uart_dout  in  DATA_W  from UART io_dout

Function
REQ-003 FSM states IDLE, GRANT, PARK; state, owner, last_owner and hold counter registered on clk.
REQ-004 IDLE: if any cpu_req set, select winner and enter GRANT next cycle; cpu_gnt[winner]=1 from that cycle (request at t -> grant at t+1).
REQ-005 Winner: if force_en=1, force_id<N_CPU and cpu_req[force_id]=1 -> force_id; else round-robin search from last_owner+1 wrapping modulo N_CPU.
REQ-006 force_en with force_id>=N_CPU or force target not requesting: treated as force_en=0.
REQ-007 GRANT: uart_rd/uart_wr/uart_addr/uart_din combinationally equal owner's inputs, strobes gated by cpu_req[owner]; non-owner strobes never reach the UART.
REQ-008 cpu_dout slice of owner = uart_dout during GRANT; all other slices, and all slices outside GRANT, = 0.
REQ-009 Hold counter cleared on GRANT entry, +1 per GRANT cycle, saturates at MAX_HOLD-1.
REQ-010 GRANT -> PARK when any of: cpu_req[owner]=0; counter at MAX_HOLD-1 and another cpu_req set; valid force (REQ-005) targeting index != owner.
REQ-011 Counter at MAX_HOLD-1 with no other requester: owner keeps grant indefinitely.
REQ-012 PARK: exactly 1 cycle, cpu_gnt=0, all uart strobes 0, last_owner <= owner, then IDLE unconditionally (owner change gap = 2 cycles with no grant).
REQ-013 cpu_gnt one-hot or zero at all times; at most one owner drives UART per cycle.
REQ-014 Simultaneous rd and wr from owner forwarded unchanged; UART resolves.

Reset
REQ-015 rst=1 at a clk edge: state IDLE, cpu_gnt=0, hold counter 0, last_owner=N_CPU-1 (first round-robin winner is CPU 0).
REQ-016 During and in the cycle after reset: uart_rd=uart_wr=0, uart_addr=0, uart_din=0, cpu_dout=0; reset mid-GRANT drops grant on the next edge, no PARK.

Verification
REQ-017 cpu_req[2] rises at cycle 5, cpu_wr[2]=1 cpu_din[2]=0x41 at cycle 6 -> cpu_gnt=0100 at 6, uart_wr=1 uart_din=0x41 at 6.
REQ-018 All cpu_req held high, MAX_HOLD=4 -> grants 0,1,2,3,0 in order, each 4 GRANT cycles, separated by PARK+IDLE.
REQ-019 CPU 0 owns, cpu_wr[1]=1 with din 0x55 -> uart_wr=0, uart_din from CPU 0, cpu_dout slice 1 = 0.
REQ-020 CPU 0 owns, force_en=1 force_id=3, cpu_req[3]=1 -> PARK next cycle, IDLE, then cpu_gnt=1000.
REQ-021 rst asserted during CPU 2 grant -> next cycle cpu_gnt=0, strobes 0; after release with all requesting, CPU 0 granted first.
REQ-022 Sole requester CPU 1 held 3000 cycles, MAX_HOLD=1024 -> cpu_gnt=0010 throughout, no PARK.

Source files
------------

// File: rtl/uart_arbiter.sv
// Shares one UART register port among N_CPU requesters. Round-robin arbitration
// with an optional forced owner, a hold limit for preemption, and a one-cycle park on every handoff.
module uart_arbiter #(
  parameter int N_CPU    = 4,
  parameter int ID_W     = 2,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CPU-1:0]        cpu_req,
  input  logic [N_CPU-1:0]        cpu_rd,
  input  logic [N_CPU-1:0]        cpu_wr,
  input  logic [N_CPU-1:0]        cpu_addr,
  input  logic [N_CPU*DATA_W-1:0] cpu_din,
  output logic [N_CPU*DATA_W-1:0] cpu_dout,
  output logic [N_CPU-1:0]        cpu_gnt,
  input  logic                    force_en,
  input  logic [ID_W-1:0]         force_id,
  output logic                    uart_rd,
  output logic                    uart_wr,
  output logic                    uart_addr,
  output logic [DATA_W-1:0]       uart_din,
  input  logic [DATA_W-1:0]       uart_dout
);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_PARK  = 2'd2;

  logic [1:0]        r_state;
  logic [ID_W-1:0]   r_owner;
  logic [ID_W-1:0]   r_last;
  logic [HOLD_W-1:0] r_hold;
  logic [N_CPU-1:0]  r_gnt;

  logic            w_force_ok;
  logic            w_rr_hit;
  logic [ID_W-1:0] w_rr;
  logic [ID_W-1:0] w_win;
  logic            w_others;
  logic            w_leave;
  logic            w_act;

  // A force that names an absent or idle CPU is simply ignored.
  assign w_force_ok = force_en && ({1'b0, force_id} < (ID_W+1)'(N_CPU)) && cpu_req[force_id];

  always_comb begin
    w_rr_hit = 1'b0;
    w_rr     = '0;
    for (int k = 1; k <= N_CPU; k++) begin
      if (!w_rr_hit && cpu_req[(int'(r_last) + k) % N_CPU]) begin
        w_rr_hit = 1'b1;
        w_rr     = ID_W'((int'(r_last) + k) % N_CPU);
      end
    end
  end

  assign w_win    = w_force_ok ? force_id : w_rr;
  assign w_others = |(cpu_req & ~(N_CPU'(1) << r_owner));
  assign w_leave  = !cpu_req[r_owner] || ((r_hold == HOLD_MAX) && w_others) ||
                    (w_force_ok && (force_id != r_owner));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= ID_W'(N_CPU - 1);
      r_hold  <= '0;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (|cpu_req) begin
          r_state <= S_GRANT;
          r_owner <= w_win;
          r_gnt   <= N_CPU'(1) << w_win;
          r_hold  <= '0;
        end
        S_GRANT: begin
          if (w_leave) begin
            r_state <= S_PARK;
            r_gnt   <= '0;
          end else if (r_hold != HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_PARK: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign cpu_gnt = r_gnt;

  // Mux is masked while rst is high so a mid-grant reset silences the UART at once.
  assign w_act = (r_state == S_GRANT) && !rst;

  always_comb begin
    uart_rd   = 1'b0;
    uart_wr   = 1'b0;
    uart_addr = 1'b0;
    uart_din  = '0;
    cpu_dout  = '0;
    if (w_act) begin
      uart_rd   = cpu_rd[r_owner] & cpu_req[r_owner];
      uart_wr   = cpu_wr[r_owner] & cpu_req[r_owner];
      uart_addr = cpu_addr[r_owner];
      uart_din  = cpu_din[r_owner*DATA_W +: DATA_W];
      cpu_dout[r_owner*DATA_W +: DATA_W] = uart_dout;
    end
  end
endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter (MAX_HOLD=4): grant latency, round-robin rotation,
// owner muxing, force preemption, reset mid-grant and long sole ownership.
module tb_uart_arbiter;
  localparam int N = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  cpu_req, cpu_rd, cpu_wr, cpu_addr;
  logic [N*DW-1:0] cpu_din, cpu_dout;
  logic [N-1:0]  cpu_gnt;
  logic          force_en;
  logic [1:0]    force_id;
  logic          uart_rd, uart_wr, uart_addr;
  logic [DW-1:0] uart_din, uart_dout;

  int nchk = 0;
  int nerr = 0;

  uart_arbiter #(.N_CPU(N), .ID_W(2), .DATA_W(DW), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_gnt(cpu_gnt),
    .force_en(force_en), .force_id(force_id), .uart_rd(uart_rd), .uart_wr(uart_wr),
    .uart_addr(uart_addr), .uart_din(uart_din), .uart_dout(uart_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    logic [3:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

    rst = 1'b1; cpu_req = '0; cpu_rd = '0; cpu_wr = '0; cpu_addr = '0; cpu_din = '0;
    force_en = 1'b0; force_id = '0; uart_dout = 8'hA5;
    cyc(); cyc();
    chk("rst_gnt", 32'(cpu_gnt), 32'h0);
    chk("rst_wr", 32'(uart_wr), 32'h0);
    chk("rst_dout", cpu_dout, 32'h0);
    rst = 1'b0;
    cyc();
    chk("idle_gnt", 32'(cpu_gnt), 32'h0);

    // All requesting: 0,1,2,3,0 each for 4 grant cycles, 2 dead cycles between
    cpu_req = 4'b1111;
    cyc();
    for (int o = 0; o < 5; o++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rr_o%0d_k%0d", o, k), 32'(cpu_gnt), 32'(seq[o]));
        cyc();
      end
      chk($sformatf("rr_park%0d", o), 32'(cpu_gnt), 32'h0);
      if (o < 4) begin
        cyc();
        chk($sformatf("rr_idle%0d", o), 32'(cpu_gnt), 32'h0);
        cyc();
      end
    end
    cpu_req = '0;
    cyc();  // IDLE, last owner = 0

    // Latency: request rises, grant on the next edge, write forwarded
    cpu_req = 4'b0100;
    chk("lat_pre", 32'(cpu_gnt), 32'h0);
    cyc();
    chk("lat_gnt", 32'(cpu_gnt), 32'h4);
    cpu_wr[2] = 1'b1; cpu_din[2*DW +: DW] = 8'h41; uart_dout = 8'h9A;
    #1;
    chk("lat_wr", 32'(uart_wr), 32'h1);
    chk("lat_din", 32'(uart_din), 32'h41);
    chk("lat_dout", cpu_dout, 32'h009A0000);
    cpu_req = '0;
    cyc();
    chk("drop_park_gnt", 32'(cpu_gnt), 32'h0);
    chk("drop_park_wr", 32'(uart_wr), 32'h0);
    cpu_wr = '0;
    cyc();  // IDLE, last owner = 2

    // Round robin from last=2 with 0 and 1 requesting -> 0
    cpu_req = 4'b0011;
    cyc();
    chk("rr_wrap", 32'(cpu_gnt), 32'h1);
    cpu_wr[1] = 1'b1; cpu_din[1*DW +: DW] = 8'h55; cpu_din[0 +: DW] = 8'h12; uart_dout = 8'h77;
    #1;
    chk("iso_wr", 32'(uart_wr), 32'h0);
    chk("iso_din", 32'(uart_din), 32'h12);
    chk("iso_dout", cpu_dout, 32'h00000077);
    cpu_wr[0] = 1'b1; cpu_rd[0] = 1'b1; cpu_addr = 4'b0001;
    #1;
    chk("both_wr", 32'(uart_wr), 32'h1);
    chk("both_rd", 32'(uart_rd), 32'h1);
    chk("addr", 32'(uart_addr), 32'h1);

    // Valid force to 3 preempts CPU 0
    force_en = 1'b1; force_id = 2'd3; cpu_req = 4'b1011;
    cyc();
    chk("frc_park_gnt", 32'(cpu_gnt), 32'h0);
    chk("frc_park_wr", 32'(uart_wr), 32'h0);
    chk("frc_park_rd", 32'(uart_rd), 32'h0);
    cyc();
    chk("frc_idle", 32'(cpu_gnt), 32'h0);
    cyc();
    chk("frc_gnt", 32'(cpu_gnt), 32'h8);
    cpu_rd = '0; cpu_wr = '0; cpu_addr = '0; force_en = 1'b0;
    cpu_req = '0;
    cyc(); cyc();  // PARK, IDLE; last owner = 3

    // Force to an idle CPU is ignored: round robin from 3 picks 1
    cpu_req = 4'b0110; force_en = 1'b1; force_id = 2'd0;
    cyc();
    chk("frc_ign_gnt", 32'(cpu_gnt), 32'h2);
    cyc();
    chk("frc_ign_hold", 32'(cpu_gnt), 32'h2);
    cpu_req = '0; force_en = 1'b0;
    cyc(); cyc();  // last owner = 1

    // Reset mid-grant
    cpu_req = 4'b0100; cpu_wr[2] = 1'b1; cpu_din[2*DW +: DW] = 8'h33;
    cyc();
    chk("r_gnt2", 32'(cpu_gnt), 32'h4);
    chk("r_wr_pre", 32'(uart_wr), 32'h1);
    rst = 1'b1;
    #1;
    chk("r_wr_during", 32'(uart_wr), 32'h0);
    chk("r_din_during", 32'(uart_din), 32'h0);
    cyc();
    chk("r_gnt_after", 32'(cpu_gnt), 32'h0);
    chk("r_dout_after", cpu_dout, 32'h0);
    rst = 1'b0; cpu_req = 4'b1111;
    #1;
    chk("r_wr_after", 32'(uart_wr), 32'h0);
    cyc();
    chk("r_first", 32'(cpu_gnt), 32'h1);
    cpu_req = '0; cpu_wr = '0;
    cyc(); cyc();

    // Sole requester keeps the grant past saturation
    cpu_req = 4'b0010;
    cyc();
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cpu_gnt !== 4'b0010) bad++;
      cyc();
    end
    chk("sole_badcycles", 32'(bad), 32'h0);
    chk("sole_end", 32'(cpu_gnt), 32'h2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
